// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch stage bus: ROM port, decode handshake, redirect input and halt status.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halted;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, halted,
        input  imem_data, out_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, halted,
        output imem_data, out_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; head entry is held in a register
// so the consumer sees registered outputs. Flush takes priority over push.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    fetch_entry_t r_head;
    fetch_entry_t r_tail;
    logic [1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && i_pop) begin
                        r_head <= i_data;
                    end else if (i_push) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end else if (i_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a pop shifts the tail into the head register.
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail  <= i_data;
                        else        r_count <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational ROM and buffers words for decode.
// Optional macro FETCH_HALT_EN stops fetching after a word with the HALT opcode.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                 DATA_W   = fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);
    import fetch_pkg::*;

    logic [ADDR_W-1:0] r_pc;
    logic              w_pop;
    logic              w_fetch_en;
    logic              w_halted;
    logic              w_valid;
    logic [1:0]        w_count;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign w_pop      = w_valid & bus.out_ready;
    // A full buffer may still fetch when its head leaves in the same cycle.
    assign w_fetch_en = !bus.redirect_valid & !w_halted & ((w_count < 2'd2) | w_pop);

    assign w_push_entry.pc    = r_pc;
    assign w_push_entry.instr = bus.imem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_pc <= RESET_PC;
        else if (bus.redirect_valid) r_pc <= bus.redirect_addr;
        else if (w_fetch_en)         r_pc <= r_pc + 1'b1;
    end

`ifdef FETCH_HALT_EN
    logic r_halted;
    logic w_halt_word;

    assign w_halt_word = (bus.imem_data[DATA_W-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_halted <= 1'b0;
        else if (bus.redirect_valid)         r_halted <= 1'b0;
        else if (w_fetch_en && w_halt_word)  r_halted <= 1'b1;
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    fetch_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fetch_en),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign bus.imem_addr = r_pc;
    assign bus.out_valid = w_valid;
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;
    assign bus.halted    = w_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences and a queue-based random model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int AW = 12;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'h000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] rom [0:4095];
    assign bus.imem_data = rom[bus.imem_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [11:0] ra;
        bit          ev;
        logic [11:0] epc;
        logic [11:0] eaddr;
    } vec_t;

    typedef struct packed {
        logic [11:0] pc;
        logic [15:0] instr;
    } ent_t;

    vec_t vt[$];
    ent_t mq[$];

    function automatic vec_t v(bit rst, bit rdy, bit rv, logic [11:0] ra,
                               bit ev, logic [11:0] epc, logic [11:0] eaddr);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.rv = rv; r.ra = ra;
        r.ev = ev; r.epc = epc; r.eaddr = eaddr;
        return r;
    endfunction

    task automatic drive(input bit rdy, input bit rv, input logic [11:0] ra);
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
    endtask

    task automatic cyc(input bit rdy, input bit rv, input logic [11:0] ra);
        drive(rdy, rv, ra);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 12'h000);
        rst_n = 1'b0;
        #1;
        chk("rst valid", bus.out_valid, 0);
        chk("rst addr",  bus.imem_addr, 12'h000);
        chk("rst pc",    bus.out_pc, 12'h000);
        chk("rst instr", bus.out_instr, 16'h0000);
        chk("rst halted", bus.halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] a;
            a = 12'(i);
            if (i < 'h200 || i >= 'hFF0) rom[i] = {4'hA, a};
            else                         rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end

        // Reset, streaming with ready high
        vt.push_back(v(1, 1, 0, 12'h000, 1, 12'h000, 12'h001));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h001, 12'h002));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h002, 12'h003));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h003, 12'h004));
        // Backpressure for 5 cycles then release
        vt.push_back(v(1, 0, 0, 12'h000, 1, 12'h000, 12'h001));
        for (int k = 0; k < 4; k++)
            vt.push_back(v(0, 0, 0, 12'h000, 1, 12'h000, 12'h002));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h001, 12'h003));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h002, 12'h004));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h003, 12'h005));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h004, 12'h006));
        // Redirect while full
        vt.push_back(v(0, 1, 1, 12'h100, 0, 12'h000, 12'h100));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h100, 12'h101));
        // Redirect near the top of the address space, wrap
        vt.push_back(v(0, 1, 1, 12'hFFE, 0, 12'h000, 12'hFFE));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'hFFE, 12'hFFF));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'hFFF, 12'h000));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h000, 12'h001));
        vt.push_back(v(0, 1, 0, 12'h000, 1, 12'h001, 12'h002));

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            cyc(vt[i].rdy, vt[i].rv, vt[i].ra);
            chk($sformatf("vec%0d valid", i), bus.out_valid, vt[i].ev);
            chk($sformatf("vec%0d addr", i), bus.imem_addr, vt[i].eaddr);
            chk($sformatf("vec%0d halted", i), bus.halted, 0);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d pc", i), bus.out_pc, vt[i].epc);
                chk($sformatf("vec%0d instr", i), bus.out_instr, {4'hA, vt[i].epc});
            end
        end

`ifdef FETCH_HALT_EN
        rom[5] = 16'hF000;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 12'h000);
            chk($sformatf("halt pc%0d", k), bus.out_pc, 12'(k));
            chk($sformatf("halt instr%0d", k), bus.out_instr, (k == 5) ? 16'hF000 : {4'hA, 12'(k)});
            chk($sformatf("halt flag%0d", k), bus.halted, (k == 5) ? 1 : 0);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 12'h000);
            chk("halt drained valid", bus.out_valid, 0);
            chk("halt frozen addr", bus.imem_addr, 12'h006);
            chk("halt held", bus.halted, 1);
        end
        cyc(1'b1, 1'b1, 12'h000);
        chk("halt redirect clear", bus.halted, 0);
        chk("halt redirect addr", bus.imem_addr, 12'h000);
        cyc(1'b1, 1'b0, 12'h000);
        chk("halt restart valid", bus.out_valid, 1);
        chk("halt restart pc", bus.out_pc, 12'h000);
        chk("halt restart addr", bus.imem_addr, 12'h001);
        rom[5] = 16'hA005;
`endif

        // Asynchronous reset with a full buffer
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 12'h000);
        chk("pre-areset valid", bus.out_valid, 1);
        chk("pre-areset addr", bus.imem_addr, 12'h002);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset valid", bus.out_valid, 0);
        chk("areset addr", bus.imem_addr, 12'h000);
        chk("areset halted", bus.halted, 0);

        // Random traffic against a queue model
        do_reset();
        begin
            logic [11:0] mpc;
            bit          mh;
            bit          rdy, rv;
            logic [11:0] ra;
            mpc = 12'h000;
            mh  = 1'b0;
            mq.delete();
            for (int c = 0; c < 2000; c++) begin
                rdy = ($urandom_range(0, 9) < 7);
                rv  = ($urandom_range(0, 19) == 0);
                ra  = ($urandom_range(0, 3) == 0) ? 12'(12'hFF0 + $urandom_range(0, 15))
                                                  : 12'($urandom_range(0, 4095));
                drive(rdy, rv, ra);
                if (mq.size() != 0 && rdy) void'(mq.pop_front());
                if (rv) begin
                    mq.delete();
                    mpc = ra;
                    mh  = 1'b0;
                end else if (!mh && mq.size() < 2) begin
                    mq.push_back({mpc, rom[mpc]});
`ifdef FETCH_HALT_EN
                    if (rom[mpc][15:12] == 4'hF) mh = 1'b1;
`endif
                    mpc = mpc + 12'd1;
                end
                @(posedge clk);
                @(negedge clk);
                chk("rnd valid", bus.out_valid, (mq.size() != 0));
                chk("rnd addr", bus.imem_addr, mpc);
                chk("rnd halted", bus.halted, mh);
                if (mq.size() != 0) begin
                    chk("rnd pc", bus.out_pc, mq[0].pc);
                    chk("rnd instr", bus.out_instr, mq[0].instr);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Fetch stage directly upstream of the 4096×16 combinational instruction ROM.
- Owns the program counter and drives the ROM address every cycle.
- Captures the returned word together with its PC into a 2-entry buffer and presents it to decode over a valid/ready handshake.
- Handles redirects (branch/jump) from downstream by flushing and reloading the PC.

## Interface
Parameters:
- ADDR_W, 12, instruction address width (ROM depth 2^ADDR_W)
- DATA_W, 16, instruction word width
- RESET_PC, 12'h000, PC value loaded on reset

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- imem_addr  out  ADDR_W  ROM address, equals PC register
- imem_data  in  DATA_W  ROM read data, combinational from imem_addr in the same cycle
- out_valid  out  1  buffer head holds an instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  DATA_W  head instruction word
- out_pc  out  ADDR_W  address the head word was fetched from
- redirect_valid  in  1  load new PC and flush
- redirect_addr  in  ADDR_W  redirect target
- halted  out  1  fetch stopped on HALT (constant 0 without FETCH_HALT_EN)

## Operation
- State: pc, 2-entry buffer of {pc, instr}, count (0..2), halted flag.
- Reset values: pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, halted=0, imem_addr=RESET_PC.
- pop = out_valid & out_ready.
- fetch_en = !redirect_valid & !halted & (count<2 | pop).
- Fetch cycle: push {pc, imem_data}, pc <= pc+1 mod 2^ADDR_W (4095 wraps to 0).
- Simultaneous push and pop: count unchanged, head advances; a full buffer with pop still fetches.
- No fetch when full without pop; pc holds and imem_addr holds.
- Redirect (highest priority):
  - A handshake completing in the same cycle counts as accepted.
  - Then the buffer is flushed (count=0), pc <= redirect_addr, halted cleared.
  - No push that cycle.
- Buffer is FIFO order; out_* are registered outputs of head entry, stable while out_valid & !out_ready.
- out_instr/out_pc hold last value when out_valid=0 (don't-care to consumer).

## Timing
- Reset release → first push at first rising edge → out_valid=1 after that edge (1-cycle latency).
- Redirect sampled at edge N → imem_addr=redirect_addr after N → push at N+1 → out_valid=1 after N+1.
- Sustained throughput 1 instr/cycle with out_ready held high.
- out_ready low for k cycles: buffer fills after 2 fetches, pc then frozen; resumes 1/cycle on first pop.
- Async reset mid-stream: all state returns to reset values immediately, buffered words discarded.

## Configuration
- FETCH_HALT_EN defined:
  - A pushed word with imem_data[15:12]==4'hF sets halted at that edge.
  - Fetching stops; the HALT word itself is still delivered.
  - Buffered words drain normally.
  - Only redirect or reset clears halted.
- Undefined: opcode not inspected, halted tied 0, fetch continues indefinitely (with wrap).

## Structure
- fetch_pkg:
  - ADDR_W/DATA_W defaults
  - HALT_OPCODE (4'hF)
  - typedef fetch_entry_t {pc, instr}
- Sub-module fetch_buffer: 2-entry synchronous FIFO of fetch_entry_t with push/pop/flush, count, registered head; flush beats push.

## Test plan
- Reset, ROM[0..3]=A000,A001,A002,A003, out_ready=1 → out_valid high from cycle 1, out_instr sequence A000..A003 with out_pc 0..3, one per cycle.
- out_ready=0 for 5 cycles after reset → count=2, imem_addr frozen at 2; release → 0,1,2,3 delivered in order, no duplicates or drops.
- Redirect to 12'h100 while buffer full and out_ready=1 → head word accepted that cycle, remaining entry discarded, next delivered out_pc=0x100 two edges later.
- Redirect to 12'hFFE, ready=1 → out_pc 0xFFE, 0xFFF, 0x000, 0x001 (wrap).
- FETCH_HALT_EN, ROM[5]=F000 → words 0..5 delivered, halted=1, imem_addr stays 6, out_valid drops after F000; redirect to 0 → halted=0, fetch restarts at 0.
- Assert rst_n low mid-stream with count=2 → out_valid=0 and imem_addr=RESET_PC immediately, no clock needed.
